// File: rtl/radix2_nonrestoring_divider.sv
// Iterative signed divider: radix-2 non-restoring magnitude core with sign fix-up.
// Truncating quotient/remainder; divide-by-zero and MIN/-1 are flagged and resolved in one cycle.
module radix2_nonrestoring_divider #(
    parameter int WIDTH       = 8,
    parameter bit CHECK_PARAM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    if (CHECK_PARAM && WIDTH < 2) begin : g_chk
        $fatal(1, "radix2_nonrestoring_divider: WIDTH must be >= 2");
    end

    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    typedef enum logic [1:0] {K_NORM, K_DBZ, K_OVF} kind_t;

    state_t state, state_nx;
    kind_t  kind;

    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q, d;
    logic [CW-1:0]    cnt;
    logic             sign_dd, sign_dv;

    logic             is_dbz, is_ovf;
    logic [WIDTH:0]   p_sh, p_step;
    logic [WIDTH-1:0] r_mag;

    assign is_dbz = (divisor == '0);
    assign is_ovf = (dividend == MIN_VAL) && (divisor == '1);

    // One non-restoring step; p[WIDTH] is the sign of the partial remainder.
    assign p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
    assign p_step = p[WIDTH] ? p_sh + {1'b0, d} : p_sh - {1'b0, d};
    // Restored remainder is in [0, D), so WIDTH-bit arithmetic is exact.
    assign r_mag  = p[WIDTH] ? p[WIDTH-1:0] + d : p[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (is_dbz || is_ovf) ? FIX : CALC;
            CALC:    if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind        <= K_NORM;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            sign_dd     <= 1'b0;
            sign_dv     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign_dd <= dividend[WIDTH-1];
                    sign_dv <= divisor[WIDTH-1];
                    // Special cases keep the raw dividend in q for the div-by-zero remainder.
                    if (is_dbz || is_ovf) q <= dividend;
                    else q <= dividend[WIDTH-1] ? -dividend : dividend;
                    d    <= divisor[WIDTH-1] ? -divisor : divisor;
                    p    <= '0;
                    cnt  <= '0;
                    kind <= is_dbz ? K_DBZ : (is_ovf ? K_OVF : K_NORM);
                end
                CALC: begin
                    p   <= p_step;
                    q   <= {q[WIDTH-2:0], ~p_step[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    case (kind)
                        K_DBZ: begin
                            quotient    <= '1;
                            remainder   <= q;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                        K_OVF: begin
                            quotient    <= MIN_VAL;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end
                        default: begin
                            quotient    <= (sign_dd ^ sign_dv) ? -q : q;
                            remainder   <= sign_dd ? -r_mag : r_mag;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_nonrestoring_divider.sv
// Directed bench for the signed divider: 8-bit hand-computed vectors, handshake and
// reset cases, plus a full 4-bit sweep against a truncating-division reference.
module tb_radix2_nonrestoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start4 = 1'b0;
    logic [7:0] dd8 = '0, dv8 = '0;
    logic [3:0] dd4 = '0, dv4 = '0;
    logic       busy8, done8, dbz8, ovf8;
    logic [7:0] q8, r8;
    logic       busy4, done4, dbz4, ovf4;
    logic [3:0] q4, r4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    radix2_nonrestoring_divider #(.WIDTH(8), .CHECK_PARAM(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dd8), .divisor(dv8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
        .div_by_zero(dbz8), .overflow(ovf8)
    );

    radix2_nonrestoring_divider #(.WIDTH(4), .CHECK_PARAM(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dd4), .divisor(dv4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4),
        .div_by_zero(dbz4), .overflow(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one 8-bit division; pulse_at >= 0 injects a 1/1 start that many cycles in.
    task automatic op8(input string tag, input int dd, input int dv, input int eq, input int er,
                       input logic edbz, input logic eovf, input int elat, input int pulse_at);
        int n, nb;
        logic [7:0] eq8, er8;
        eq8 = 8'(eq);
        er8 = 8'(er);
        @(negedge clk);
        dd8 = 8'(dd); dv8 = 8'(dv); start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n  = 0;
        nb = busy8 ? 1 : 0;
        while (!done8 && n < 40) begin
            if (n == pulse_at) begin
                dd8 = 8'd1; dv8 = 8'd1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (busy8) nb++;
        end
        start8 = 1'b0;
        chk({tag, ".lat"},  n, elat);
        chk({tag, ".busy"}, nb, elat);
        chk({tag, ".q"},    {24'b0, q8}, {24'b0, eq8});
        chk({tag, ".r"},    {24'b0, r8}, {24'b0, er8});
        chk({tag, ".dbz"},  {31'b0, dbz8}, {31'b0, edbz});
        chk({tag, ".ovf"},  {31'b0, ovf8}, {31'b0, eovf});
        @(posedge clk); #1;
        chk({tag, ".pulse"}, {31'b0, done8}, 32'd0);
        chk({tag, ".hold"},  {24'b0, q8}, {24'b0, eq8});
    endtask

    task automatic op4(input int a, input int b);
        int n, eq, er, elat;
        if (b == 0) begin
            eq = -1; er = a; elat = 1;
        end else if (a == -8 && b == -1) begin
            eq = -8; er = 0; elat = 1;
        end else begin
            eq = a / b; er = a % b; elat = 5;
        end
        @(negedge clk);
        dd4 = 4'(a); dv4 = 4'(b); start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("w4 %0d/%0d lat", a, b), n, elat);
        chk($sformatf("w4 %0d/%0d q", a, b), {28'b0, q4}, {28'b0, 4'(eq)});
        chk($sformatf("w4 %0d/%0d r", a, b), {28'b0, r4}, {28'b0, 4'(er)});
        chk($sformatf("w4 %0d/%0d flags", a, b), {30'b0, dbz4, ovf4},
            {30'b0, (b == 0), (a == -8 && b == -1)});
        @(posedge clk); #1;
        chk($sformatf("w4 %0d/%0d pulse", a, b), {31'b0, done4}, 32'd0);
    endtask

    initial begin
        int n, m;
        logic seen;

        #12;
        chk("rst.busy", {31'b0, busy8}, 32'd0);
        chk("rst.done", {31'b0, done8}, 32'd0);
        chk("rst.q",    {24'b0, q8}, 32'd0);
        chk("rst.r",    {24'b0, r8}, 32'd0);
        chk("rst.flags", {30'b0, dbz8, ovf8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8("100/7",   100,  7,  14,  2, 1'b0, 1'b0, 9, -1);
        op8("-100/7", -100,  7, -14, -2, 1'b0, 1'b0, 9, -1);
        op8("100/-7",  100, -7, -14,  2, 1'b0, 1'b0, 9, -1);
        op8("-100/-7",-100, -7,  14, -2, 1'b0, 1'b0, 9, -1);
        op8("3/10",      3, 10,   0,  3, 1'b0, 1'b0, 9, -1);
        op8("-128/1", -128,  1,-128,  0, 1'b0, 1'b0, 9, -1);
        op8("5/0",       5,  0,  -1,  5, 1'b1, 1'b0, 1, -1);
        op8("-128/-1",-128, -1,-128,  0, 1'b0, 1'b1, 1, -1);
        op8("6/3",       6,  3,   2,  0, 1'b0, 1'b0, 9, -1);
        op8("ignore",  100,  7,  14,  2, 1'b0, 1'b0, 9, 2);

        // Start held through done: second operation is captured in the done cycle.
        @(negedge clk);
        dd8 = 8'd100; dv8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        dd8 = 8'd20; dv8 = 8'd3;
        n = 0;
        while (!done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b.lat1", n, 9);
        chk("b2b.q1", {24'b0, q8}, 32'd14);
        chk("b2b.r1", {24'b0, r8}, 32'd2);
        m = 0;
        do begin
            @(posedge clk); #1;
            start8 = 1'b0;
            m++;
        end while (!done8 && m < 40);
        chk("b2b.lat2", m, 10);
        chk("b2b.q2", {24'b0, q8}, 32'd6);
        chk("b2b.r2", {24'b0, r8}, 32'd2);

        // Reset mid-division aborts without a done pulse.
        @(negedge clk);
        dd8 = 8'd100; dv8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.busy", {31'b0, busy8}, 32'd0);
        chk("abort.done", {31'b0, done8}, 32'd0);
        chk("abort.q",    {24'b0, q8}, 32'd0);
        chk("abort.r",    {24'b0, r8}, 32'd0);
        chk("abort.flags", {30'b0, dbz8, ovf8}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        chk("abort.nodone", {31'b0, seen}, 32'd0);
        op8("50/5", 50, 5, 10, 0, 1'b0, 1'b0, 9, -1);

        for (int a = -8; a < 8; a++)
            for (int b = -8; b < 8; b++)
                op4(a, b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
